// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-key synchronise/debounce stage with press, release and encoded key events
// Optional long-press detection is built when KEY_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int LONG_CYC     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic [3:0] key_long
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_UP,
        ST_WAIT_DOWN,
        ST_DOWN,
        ST_WAIT_UP
    } state_t;

    generate
        if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_params
            $error("key_debounce: need DEBOUNCE_CYC >= 2 and LONG_CYC > DEBOUNCE_CYC");
        end
    endgenerate

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    state_t        state     [4];
    state_t        state_nxt [4];
    logic [CW-1:0] cnt       [4];
    logic [CW-1:0] cnt_nxt   [4];
    logic [3:0]    press_evt;
    logic [3:0]    release_evt;
    logic [3:0]    held;
    logic [3:0]    press_q;
    logic [3:0]    release_q;
    logic [1:0]    press_code;

    // Inverted sense: a 1 on sync2 means the key is physically pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= ST_UP;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Counter is cleared on every exit from a WAIT state, so it never wraps.
    always_comb begin
        press_evt   = 4'b0000;
        release_evt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_UP: begin
                    if (sync2[i]) begin
                        state_nxt[i] = ST_WAIT_DOWN;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ST_WAIT_DOWN: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = ST_UP;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = ST_DOWN;
                        cnt_nxt[i]   = '0;
                        press_evt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = ST_WAIT_UP;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ST_WAIT_UP: begin
                    if (sync2[i]) begin
                        state_nxt[i] = ST_DOWN;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i]   = ST_UP;
                        cnt_nxt[i]     = '0;
                        release_evt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt[i] = ST_UP;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // WAIT_UP still reports the key as held, so the level only drops with the release pulse.
    always_comb begin
        held = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            held[i] = (state[i] == ST_DOWN) || (state[i] == ST_WAIT_UP);
        end
    end

    always_comb begin
        press_code = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (press_q[i]) begin
                press_code = 2'(i);
            end
        end
    end

    // Transition pulses are captured with the FSM edge, then presented through one output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q     <= 4'b0000;
            release_q   <= 4'b0000;
            key_level   <= 4'b0000;
            key_press   <= 4'b0000;
            key_release <= 4'b0000;
            key_valid   <= 1'b0;
            key_code    <= 2'b00;
        end else begin
            press_q     <= press_evt;
            release_q   <= release_evt;
            key_level   <= held;
            key_press   <= press_q;
            key_release <= release_q;
            key_valid   <= |press_q;
            if (|press_q) begin
                key_code <= press_code;
            end
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_cnt [4];
    logic [3:0]    long_done;
    logic [3:0]    long_q;

    // Hold time accrues only in DOWN; a WAIT_UP bounce pauses it rather than restarting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hold_cnt[i] <= '0;
            end
            long_done <= 4'b0000;
            long_q    <= 4'b0000;
            key_long  <= 4'b0000;
        end else begin
            key_long <= long_q;
            for (int i = 0; i < 4; i++) begin
                long_q[i] <= 1'b0;
                if (press_evt[i]) begin
                    hold_cnt[i]  <= '0;
                    long_done[i] <= 1'b0;
                end else if (state[i] == ST_DOWN && !long_done[i]) begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
                    if (hold_cnt[i] == HOLD_LAST) begin
                        long_q[i]    <= 1'b1;
                        long_done[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign key_long = 4'b0000;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce against a run-length reference model
// Long-press checks are active when KEY_LONGPRESS_EN is defined.
module tb_key_debounce;

    localparam int DCYC = 4;
    localparam int LCYC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'b1111;
    logic [3:0] key_level, key_press, key_release, key_long;
    logic       key_valid;
    logic [1:0] key_code;

    int checks = 0;
    int errors = 0;

    key_debounce #(.DEBOUNCE_CYC(DCYC), .LONG_CYC(LCYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the synchronised input has disagreed with it
    // for DCYC consecutive samples; outputs appear one edge after the flip.
    logic [3:0] m_s1, m_s2, m_lvl, ev_press, ev_rel, ev_long, sample;
    int         m_run [4];
    int         m_hold [4];
    logic [3:0] m_fired;
    logic [3:0] exp_level, exp_press, exp_release, exp_long;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic       was_down;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; ev_press = 0; ev_rel = 0; ev_long = 0; m_fired = 0;
            exp_level = 0; exp_press = 0; exp_release = 0; exp_long = 0; exp_valid = 0; exp_code = 0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
                m_hold[i] = 0;
            end
        end else begin
            exp_press   = ev_press;
            exp_release = ev_rel;
            exp_level   = m_lvl;
            exp_long    = ev_long;
            exp_valid   = |ev_press;
            for (int i = 3; i >= 0; i--) if (ev_press[i]) exp_code = 2'(i);
            sample = m_s2;
            m_s2 = m_s1;
            m_s1 = ~key_n;
            ev_press = 0; ev_rel = 0; ev_long = 0;
            for (int i = 0; i < 4; i++) begin
                was_down = m_lvl[i] && (m_run[i] == 0);
`ifdef KEY_LONGPRESS_EN
                if (was_down && !m_fired[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] == LCYC) begin
                        ev_long[i] = 1'b1;
                        m_fired[i] = 1'b1;
                    end
                end
`endif
                m_run[i] = (sample[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DCYC) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) begin
                        ev_press[i] = 1'b1;
                        m_hold[i]   = 0;
                        m_fired[i]  = 1'b0;
                    end else begin
                        ev_rel[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [18:0] dut_vec();
        return {key_level, key_press, key_release, key_valid, key_code, key_long};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {exp_level, exp_press, exp_release, exp_valid, exp_code, exp_long};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        key_n = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== 19'd0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h want=0", c, dut_vec());
            end
        end
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s_model cyc=%0d got=%h want=%h", name, c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int seen;
        key_n = 4'b1011;
        seen = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL press_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (seen < 0 && key_press != 4'b0000) begin
                seen = c;
                checks++;
                if ({key_press, key_valid, key_code} !== {4'b0100, 1'b1, 2'd2}) begin
                    errors++;
                    $display("FAIL press_value got=%b/%b/%0d want=0100/1/2", key_press, key_valid, key_code);
                end
            end
        end
        checks++;
        if (seen != DCYC + 2) begin
            errors++;
            $display("FAIL press_latency got=%0d want=%0d", seen, DCYC + 2);
        end
        checks++;
        if (key_level !== 4'b0100) begin
            errors++;
            $display("FAIL press_level got=%b want=0100", key_level);
        end
        key_n = 4'b1111;
        seen = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL release_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (seen < 0 && key_release == 4'b0100) seen = c;
        end
        checks++;
        if (seen != DCYC + 2) begin
            errors++;
            $display("FAIL release_latency got=%0d want=%0d", seen, DCYC + 2);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (c < 20) key_n[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            pulses += (key_press != 0 || key_release != 0 || key_level != 0) ? 1 : 0;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_quiet got=%0d want=0", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int valids;
        logic [3:0] pv;
        logic [1:0] cv;
        valids = 0; pv = 0; cv = 0;
        key_n = 4'b0101;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simul_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (key_valid) begin
                valids++;
                pv = key_press;
                cv = key_code;
            end
        end
        checks++;
        if ({valids, pv, cv} !== {32'd1, 4'b1010, 2'd1}) begin
            errors++;
            $display("FAIL simul_event got=%0d/%b/%0d want=1/1010/1", valids, pv, cv);
        end
        key_n = 4'b1111;
        idle(12, "simul_rel");
    endtask

    task automatic test_reset_mid();
        int seen, rels;
        key_n = 4'b1110;
        idle(10, "mid_press");
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec() !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset got=%h want=0", dut_vec());
        end
        rst = 1'b0;
        seen = -1; rels = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (seen < 0 && key_press[0]) seen = c;
            if (key_release != 0) rels++;
        end
        checks++;
        if (seen != DCYC + 2 || rels != 0) begin
            errors++;
            $display("FAIL mid_repress got=%0d/%0d want=%0d/0", seen, rels, DCYC + 2);
        end
        key_n = 4'b1111;
        idle(12, "mid_rel");
    endtask

    task automatic test_long();
        int p, l, longs;
        p = -1; l = -1; longs = 0;
        key_n = 4'b0111;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (p < 0 && key_press[3]) p = c;
            if (key_long[3]) begin
                longs++;
                if (l < 0) l = c;
            end
        end
        key_n = 4'b1111;
        idle(12, "long_rel");
        for (int c = 0; c < 24; c++) begin
            key_n = (c < 14) ? 4'b0111 : 4'b1111;
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL short_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
            if (key_long != 0) longs += 100;
        end
`ifdef KEY_LONGPRESS_EN
        checks++;
        if (longs != 1 || l - p != LCYC) begin
            errors++;
            $display("FAIL long_pulse got=%0d/%0d want=1/%0d", longs, l - p, LCYC);
        end
`else
        checks++;
        if (longs != 0) begin
            errors++;
            $display("FAIL long_tied got=%0d want=0", longs);
        end
`endif
    endtask

    task automatic test_random();
        int rem [4];
        for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 4);
                end
                rem[i]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_long();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
